// File: rtl/led_arb_pkg.sv
// rtl/led_arb_pkg.sv - shared types, widths and round-robin pick for the LED bank arbiter
package led_arb_pkg;

  localparam int LED_W   = 16;
  localparam int MAX_REQ = 8;
  localparam int OWNER_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [OWNER_W-1:0] idx;
  } rr_pick_t;

  // Scans n requesters beginning at start (wrapping); the first asserted request wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input int start,
                                       input int n);
    rr_pick_t r;
    int idx;
    logic [OWNER_W-1:0] sel;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (start + i) % n;
      sel = idx[OWNER_W-1:0];
      if (i < n && !r.found && req[sel]) begin
        r.found = 1'b1;
        r.idx   = sel;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running prescaler with synchronous clear and one-cycle tick
module led_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk100m,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  logic [31:0] cnt;

  assign tick = (cnt == 32'(TICK_DIV - 1));

  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin LED bank arbiter with dwell timing; LED_ARB_IDLE_ROTATE_EN enables idle rotation
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int DWELL_TICKS = 4
) (
  input  logic                       clk100m,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [LED_W*NUM_REQ-1:0]   pattern,
  output logic [NUM_REQ-1:0]         grant,
  output logic [OWNER_W-1:0]         owner,
  output logic                       busy,
  output logic [LED_W-1:0]           leds
);

  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
`ifdef LED_ARB_IDLE_ROTATE_EN
  localparam logic [LED_W-1:0] LED_IDLE = 16'h0001;
`else
  localparam logic [LED_W-1:0] LED_IDLE = 16'h0000;
`endif

  arb_state_t           state;
  logic [OWNER_W-1:0]   last_owner;
  logic [DW-1:0]        dwell;
  logic                 tick;
  logic                 clr;
  logic [MAX_REQ-1:0]   req_ext;
  rr_pick_t             pick;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [LED_W-1:0]     win_pat;
  logic [LED_W-1:0]     own_pat;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk100m (clk100m),
    .rst_n   (rst_n),
    .clr     (clr),
    .tick    (tick)
  );

  // IDLE searches after the last owner; SWITCH searches after the owner just released.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    if (state == SWITCH) begin
      pick = rr_pick(req_ext, int'(owner) + 1, NUM_REQ);
    end else begin
      pick = rr_pick(req_ext, int'(last_owner) + 1, NUM_REQ);
    end
    clr        = (state != GRANT) && pick.found;
    win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick.idx;
    win_pat    = pattern[int'(pick.idx) * LED_W +: LED_W];
    own_pat    = pattern[int'(owner) * LED_W +: LED_W];
  end

  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      busy       <= 1'b0;
      last_owner <= OWNER_W'(NUM_REQ - 1);
      dwell      <= '0;
      leds       <= LED_IDLE;
    end else if (clr) begin
      state      <= GRANT;
      grant      <= win_onehot;
      owner      <= pick.idx;
      last_owner <= pick.idx;
      busy       <= 1'b1;
      dwell      <= '0;
      leds       <= win_pat;
    end else begin
      case (state)
        IDLE: begin
`ifdef LED_ARB_IDLE_ROTATE_EN
          if (tick) begin
            leds <= {leds[LED_W-2:0], leds[LED_W-1]};
          end
`endif
        end
        GRANT: begin
          leds <= own_pat;
          // Release and dwell expiry lead to the same single SWITCH cycle.
          if (!req_ext[owner] || (tick && dwell == DWELL_LAST)) begin
            state <= SWITCH;
            grant <= '0;
          end else if (tick) begin
            dwell <= dwell + DW'(1);
          end
        end
        SWITCH: begin
          state <= IDLE;
          busy  <= 1'b0;
          leds  <= LED_IDLE;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          leds  <= LED_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// tb/tb_led_bank_arbiter.sv - directed self-checking bench for led_bank_arbiter
module tb_led_bank_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TICK_DIV    = 4;
  localparam int DWELL_TICKS = 3;
`ifdef LED_ARB_IDLE_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  localparam logic [15:0] LED_RST = ROT ? 16'h0001 : 16'h0000;

  logic        clk100m = 1'b0;
  logic        rst_n   = 1'b1;
  logic [3:0]  req     = '0;
  logic [63:0] pattern = {16'h4444, 16'h2222, 16'hA5A5, 16'h1111};
  logic [3:0]  grant;
  logic [2:0]  owner;
  logic        busy;
  logic [15:0] leds;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic [3:0] rr_seq [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

  always #5 clk100m = ~clk100m;

  led_bank_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TICK_DIV    (TICK_DIV),
    .DWELL_TICKS (DWELL_TICKS)
  ) dut (
    .clk100m (clk100m),
    .rst_n   (rst_n),
    .req     (req),
    .pattern (pattern),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .leds    (leds)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk100m);
    #1;
  endtask

  task automatic hold_len(input logic [3:0] g, output int cnt);
    cnt = 0;
    while (grant === g && cnt < 100) begin
      cnt++;
      step(1);
    end
  endtask

  task automatic do_reset(input logic [3:0] r);
    step(1);
    rst_n = 1'b0;
    req   = r;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_grant", grant, 4'b0000);
    check_eq("rst_owner", owner, 3'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_leds", leds, LED_RST);
    step(1);
    rst_n = 1'b1;

    // idle rotation: one shift per 4-cycle tick, wrapping 8000 -> 0001
    step(3);
    check_eq("idle_pre_tick", leds, LED_RST);
    step(1);
    check_eq("idle_tick1", leds, ROT ? 16'h0002 : 16'h0000);
    step(4);
    check_eq("idle_tick2", leds, ROT ? 16'h0004 : 16'h0000);
    step(52);
    check_eq("idle_tick15", leds, ROT ? 16'h8000 : 16'h0000);
    step(4);
    check_eq("idle_wrap", leds, ROT ? 16'h0001 : 16'h0000);

    // single requester
    req = 4'b0010;
    check_eq("single_pre", grant, 4'b0000);
    step(1);
    check_eq("single_grant", grant, 4'b0010);
    check_eq("single_leds", leds, 16'hA5A5);
    check_eq("single_owner", owner, 3'd1);
    check_eq("single_busy", busy, 1'b1);
    hold_len(4'b0010, n);
    check_eq("single_len", n, 12);
    check_eq("single_gap", grant, 4'b0000);
    check_eq("single_gap_busy", busy, 1'b1);
    check_eq("single_gap_leds", leds, 16'hA5A5);
    step(1);
    check_eq("single_regrant", grant, 4'b0010);

    // round-robin with req 1011 held
    do_reset(4'b1011);
    step(1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_grant%0d", i), grant, rr_seq[i]);
      hold_len(rr_seq[i], n);
      check_eq($sformatf("rr_len%0d", i), n, 12);
      check_eq($sformatf("rr_gap%0d", i), grant, 4'b0000);
      step(1);
    end

    // early release by owner 2 with requester 3 waiting
    do_reset(4'b0100);
    step(1);
    check_eq("rel_grant2", grant, 4'b0100);
    req = 4'b1100;
    step(1);
    pattern[47:32] = 16'h3C3C;
    step(1);
    check_eq("rel_pat_follow", leds, 16'h3C3C);
    step(2);
    check_eq("rel_still2", grant, 4'b0100);
    req = 4'b1000;
    step(1);
    check_eq("rel_switch_grant", grant, 4'b0000);
    check_eq("rel_switch_leds", leds, 16'h3C3C);
    check_eq("rel_switch_busy", busy, 1'b1);
    step(1);
    check_eq("rel_grant3", grant, 4'b1000);
    check_eq("rel_owner3", owner, 3'd3);
    check_eq("rel_leds3", leds, 16'h4444);

    // asynchronous reset while owner 1 holds the bank
    do_reset(4'b0010);
    step(1);
    check_eq("ar_grant1", grant, 4'b0010);
    step(3);
    rst_n = 1'b0;
    #2;
    check_eq("ar_grant", grant, 4'b0000);
    check_eq("ar_leds", leds, LED_RST);
    check_eq("ar_busy", busy, 1'b0);
    check_eq("ar_owner", owner, 3'd0);
    req   = 4'b0110;
    rst_n = 1'b1;
    step(1);
    check_eq("ar_first_grant", grant, 4'b0010);
    check_eq("ar_first_owner", owner, 3'd1);

    // release lands on the same cycle as dwell expiry
    step(11);
    check_eq("sim_last_cycle", grant, 4'b0010);
    req = 4'b1100;
    step(1);
    check_eq("sim_switch", grant, 4'b0000);
    check_eq("sim_switch_busy", busy, 1'b1);
    step(1);
    check_eq("sim_next_grant", grant, 4'b0100);
    check_eq("sim_next_owner", owner, 3'd2);
    hold_len(4'b0100, n);
    check_eq("sim_next_len", n, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
